// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants and arbitration type for the RAM-backed FIFO controller.
// The defaults match the 4 x 3-bit single-port RAM this controller drives.
package ram_fifo_ctrl_pkg;

  localparam int DW    = 3;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  // Port priority used when a write and a read both want the shared RAM port.
  typedef enum logic {
    WR = 1'b0,
    RD = 1'b1
  } prio_t;

endpackage

// File: rtl/wrap_ptr.sv
// AW-bit circular pointer for the RAM.
// It advances on inc and wraps naturally from 2**AW-1 back to 0.
module wrap_ptr #(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)      ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Circular FIFO controller for an external single-port RAM with asynchronous read.
// One access per cycle: a toggling priority flag shares the port when a write and a read contend.
module ram_fifo_ctrl #(
  parameter int DW = ram_fifo_ctrl_pkg::DW,
  parameter int AW = ram_fifo_ctrl_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic [AW:0]   fill
);

  import ram_fifo_ctrl_pkg::*;

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(2**AW);

  prio_t         prio;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          not_full;
  logic          not_empty;
  logic          wr_req;
  logic          rd_req;
  logic          wr_gnt;
  logic          rd_gnt;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    not_full  = (fill < FULL_LEVEL);
    not_empty = (fill != '0);
    wr_req    = in_valid && not_full;
    rd_req    = not_empty && (!out_valid || out_ready);
    // in_ready must not look at in_valid, so only a pending read with RD priority blocks it.
    in_ready  = !rst && not_full && !(rd_req && prio == RD);
    wr_gnt    = in_valid && in_ready;
    rd_gnt    = !rst && rd_req && !wr_gnt;
    ram_we    = wr_gnt;
    ram_addr  = wr_gnt ? wr_ptr : rd_ptr;
    ram_din   = in_data;
  end

  wrap_ptr #(.AW(AW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_gnt),
    .ptr (wr_ptr)
  );

  wrap_ptr #(.AW(AW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_gnt),
    .ptr (rd_ptr)
  );

  // The RAM itself is not cleared on reset: fill=0 makes its stale words unreachable.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      prio      <= WR;
    end else begin
      if (wr_gnt)      fill <= fill + 1'b1;
      else if (rd_gnt) fill <= fill - 1'b1;

      if (rd_gnt) begin
        out_data  <= ram_dout;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (wr_req && rd_req) prio <= (prio == WR) ? RD : WR;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed and randomized checks of ram_fifo_ctrl against a behavioural 4 x 3-bit RAM.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_data;
  logic       ram_we;
  logic [1:0] ram_addr;
  logic [2:0] ram_din;
  logic [2:0] ram_dout;
  logic [2:0] fill;

  logic [2:0] mem [4];

  int checks = 0;
  int errors = 0;

  ram_fifo_ctrl #(.DW(3), .AW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .fill      (fill)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
  assign ram_dout = mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] got [$];
    logic [2:0] q [$];
    logic [2:0] exp_word;
    int         idx;
    logic       acc;

    for (int i = 0; i < 4; i++) mem[i] = 3'd0;

    // Reset with a handshake offered: it must be ignored.
    rst = 1'b1; in_valid = 1'b1; in_data = 3'd7; out_ready = 1'b0;
    tick; tick;
    check("rst_in_ready", in_ready, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_fill", fill, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);

    rst = 1'b0; in_valid = 1'b0; #1;
    check("idle_in_ready", in_ready, 1);

    // Fill with 1..4, out_ready low; the read side wins the second contention.
    in_valid = 1'b1; in_data = 3'd1; #1;
    check("a_in_ready", in_ready, 1);
    check("a_ram_we", ram_we, 1);
    check("a_ram_addr", ram_addr, 0);
    tick;
    in_data = 3'd2; #1;
    check("b_in_ready", in_ready, 1);
    check("b_ram_addr", ram_addr, 1);
    tick;
    in_data = 3'd3; #1;
    check("c_in_ready", in_ready, 0);
    check("c_ram_we", ram_we, 0);
    check("c_ram_addr", ram_addr, 0);
    tick;
    check("c_out_valid", out_valid, 1);
    check("c_out_data", out_data, 1);
    check("c_fill", fill, 1);
    #1;
    check("d_in_ready", in_ready, 1);
    check("d_ram_addr", ram_addr, 2);
    tick;
    in_data = 3'd4; #1;
    check("e_ram_addr", ram_addr, 3);
    tick;
    in_valid = 1'b0; #1;
    check("fill_after_4", fill, 3);
    check("out_data_after_4", out_data, 1);
    check("in_ready_after_4", in_ready, 1);

    // One more word fills the RAM; pointer has wrapped to 0.
    in_valid = 1'b1; in_data = 3'd5; #1;
    check("push5_ram_we", ram_we, 1);
    check("push5_ram_addr", ram_addr, 0);
    tick;
    in_data = 3'd6; #1;
    check("full_fill", fill, 4);
    check("full_in_ready", in_ready, 0);
    check("full_ram_we", ram_we, 0);
    tick; tick;
    check("hold_fill", fill, 4);
    check("hold_out_data", out_data, 1);
    check("hold_ram_we", ram_we, 0);

    // Each out_ready pulse pops exactly one word.
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    out_ready = 1'b0; #1;
    check("pulse1_out_data", out_data, 2);
    check("pulse1_fill", fill, 3);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0; #1;
    check("pulse2_out_data", out_data, 3);
    check("pulse2_fill", fill, 2);
    tick;
    check("pulse2_hold_fill", fill, 2);
    check("pulse2_hold_valid", out_valid, 1);

    // Reset mid-flight with fill=2, out_valid=1 and a handshake offered.
    rst = 1'b1; in_valid = 1'b1; in_data = 3'd7; #1;
    check("rst2_in_ready", in_ready, 0);
    check("rst2_ram_we", ram_we, 0);
    tick;
    rst = 1'b0; in_valid = 1'b0; #1;
    check("rst2_fill", fill, 0);
    check("rst2_out_valid", out_valid, 0);
    check("rst2_out_data", out_data, 0);
    tick;
    check("rst2_discard_fill", fill, 0);

    // Push 6 from empty: visible one cycle after acceptance.
    in_valid = 1'b1; in_data = 3'd6; #1;
    check("push6_ram_we", ram_we, 1);
    check("push6_ram_addr", ram_addr, 0);
    tick;
    in_valid = 1'b0; #1;
    check("push6_early_valid", out_valid, 0);
    check("push6_fill", fill, 1);
    tick;
    check("push6_out_valid", out_valid, 1);
    check("push6_out_data", out_data, 6);
    check("push6_fill_after", fill, 0);

    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("drop_out_valid", out_valid, 0);

    // Push 5 at wr_ptr=1.
    in_valid = 1'b1; in_data = 3'd5; #1;
    check("push5b_ram_we", ram_we, 1);
    check("push5b_ram_addr", ram_addr, 1);
    tick;
    in_valid = 1'b0;
    tick;
    check("push5b_out_valid", out_valid, 1);
    check("push5b_out_data", out_data, 5);

    // Streaming 0..7 with out_ready high; 5 is still in the output register.
    out_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 100 && got.size() < 9; c++) begin
      in_valid = (idx < 8);
      in_data  = 3'(idx);
      #1;
      if (out_valid) got.push_back(out_data);
      acc = in_valid && in_ready;
      tick;
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("stream_count", got.size(), 9);
    if (got.size() == 9) begin
      check("stream_word0", got[0], 5);
      for (int i = 1; i < 9; i++) check($sformatf("stream_word%0d", i), got[i], i - 1);
    end

    // Random traffic against a reference queue.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 3'($urandom_range(0, 7));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          errors++;
          $error("FAIL rnd_underflow: observed output word %0d expected none", out_data);
        end else begin
          exp_word = q.pop_front();
          check("rnd_data", out_data, exp_word);
        end
      end
      check("rnd_we", ram_we, in_valid && in_ready);
      if (in_valid && in_ready) q.push_back(in_data);
      tick;
      check("rnd_level", int'(fill) + int'(out_valid), q.size());
      check("rnd_fill_max", fill <= 3'd4, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst; all state SHALL update on posedge clk only.
REQ-002 Parameter DW, default 3: data width, matching the 3-bit-word RAM.
REQ-003 Parameter AW, default 2: address width; depth is 2**AW = 4 words.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 in_valid  input  1  upstream word present.
REQ-007 in_ready  output  1  block accepts the upstream word this cycle.
REQ-008 in_data  input  DW  upstream word.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_ready  input  1  downstream consumes out_data this cycle.
REQ-011 out_data  output  DW  registered output word.
REQ-012 ram_we  output  1  RAM write enable.
REQ-013 ram_addr  output  AW  RAM address, shared by read and write.
REQ-014 ram_din  output  DW  RAM write data.
REQ-015 ram_dout  input  DW  RAM asynchronous read data for ram_addr.
REQ-016 fill  output  AW+1  number of words held in RAM (0..4), excluding the output register.

Function
REQ-017 The block SHALL operate the single-port RAM as a circular FIFO with write pointer wr_ptr and read pointer rd_ptr, each AW bits, each wrapping 3->0.
REQ-018 Write request: wr_req = in_valid && fill < 4. Read request: rd_req = fill > 0 && (!out_valid || out_ready).
REQ-019 prio flag (WR/RD) SHALL arbitrate the port: in_ready = (fill < 4) && !(rd_req && prio == RD). in_ready SHALL NOT depend on in_valid.
REQ-020 Write grant: wr_gnt = in_valid && in_ready. Read grant: rd_gnt = rd_req && !wr_gnt. At most one grant per cycle.
REQ-021 prio SHALL toggle only in cycles where wr_req and rd_req are both asserted; otherwise it SHALL hold.
REQ-022 ram_we = wr_gnt; ram_addr = wr_gnt ? wr_ptr : rd_ptr; ram_din = in_data. All are combinational.
REQ-023 On wr_gnt: wr_ptr++ and fill++ at the clock edge.
REQ-024 On rd_gnt: out_data <= ram_dout, out_valid <= 1, rd_ptr++, fill--.
REQ-025 Without rd_gnt: if out_valid && out_ready then out_valid <= 0; otherwise out_valid and out_data SHALL hold.
REQ-026 Latency: a word written at edge N SHALL appear with out_valid=1 after edge N+1 at the earliest.
REQ-027 Full (fill=4): in_ready=0 and ram_we=0. Empty (fill=0): no read grant. fill SHALL never exceed 4 or go below 0.
REQ-028 Order SHALL be strict FIFO across pointer wrap-around, with no loss or duplication.

Reset
REQ-029 While rst=1: wr_ptr=0, rd_ptr=0, fill=0, out_valid=0, out_data=0, prio=WR; in_ready=0 and ram_we=0 combinationally.
REQ-030 A handshake presented during a reset cycle SHALL be discarded. RAM contents SHALL NOT be cleared; stale data is unreachable because fill=0.

Structure
REQ-031 A shared package SHALL hold DW, AW, DEPTH=4 and the prio enum (WR, RD).
REQ-032 One sub-module, wrap_ptr (AW-bit counter with inc enable and sync reset), SHALL be instantiated twice, for wr_ptr and rd_ptr. The RAM SHALL be instantiated outside this block.

Verification
REQ-033 Reset, then in_valid=1 with data 1,2,3,4 and out_ready=0 -> fill reaches 4 and in_ready=0. out_valid rises once RAM data moves to the output register; if the read-side wins, fill ends at 3, otherwise 4.
REQ-034 Push 5 -> ram_we=1, ram_addr=wr_ptr at the edge; out_data=5 and out_valid=1 one cycle after acceptance.
REQ-035 Continuous in_valid=1 and out_ready=1 with data 0..7 -> out_data sequence is 0..7 in order; pointers wrap twice; prio alternates on contention cycles.
REQ-036 fill=4, out_ready held 0, then pulsed -> exactly one word popped per pulse; no ram_we while full.
REQ-037 Assert rst with fill=2 and out_valid=1 -> next cycle fill=0, out_valid=0, out_data=0; a later push of 6 reads back as 6.
REQ-038 Random valid/ready for 1000 cycles against a reference queue model -> no mismatch, and no cycle with two grants.
